fifo_word_serializer: RTL and testbench
=======================================

// Module: fifo_word_serializer
// PURPOSE
// - Sits directly on the pop side of the FIFO; consumes its DATA_WIDTH+1-bit words.
// - Input word format: bit DATA_WIDTH = end-of-packet flag, bits DATA_WIDTH-1:0 = payload.
// - Splits each payload into BEATS = DATA_WIDTH/SER_WIDTH narrow beats, LSB beat first.
// - Drives a narrow valid/grant output stream and keeps a running count of completed packets.
// PARAMETERS
// - DATA_WIDTH  32  payload width of one FIFO word, excluding the flag bit
// - SER_WIDTH   8   output beat width; DATA_WIDTH % SER_WIDTH == 0 is required (elaboration $error otherwise)
// - CNT_WIDTH   16  width of the packet counter
// PORTS
// - clk           in   1              rising-edge clock
// - rst           in   1              asynchronous, active-high reset
// - push_data_i   in   DATA_WIDTH+1   word from FIFO (pop_data_o of FIFO)
// - push_valid_i  in   1              FIFO has a word (pop_valid_o of FIFO)
// - push_grant_o  out  1              serializer takes the word this cycle (to FIFO pop_grant_i)
// - pop_data_o    out  SER_WIDTH      current beat
// - pop_last_o    out  1              final beat of a flagged word (end of packet)
// - pop_valid_o   out  1              beat on pop_data_o is valid
// - pop_grant_i   in   1              sink accepts the beat this cycle
// - pkt_count_o   out  CNT_WIDTH      number of packets fully emitted since reset
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, beat_idx=0, word_q=0, last_q=0.
//   pop_valid_o=0, pop_data_o=0, pop_last_o=0, pkt_count_o=0, push_grant_o=1.
// - Transfers: input xfer = push_valid_i & push_grant_o; output xfer = pop_valid_o & pop_grant_i.
// - FSM IDLE: push_grant_o=1, pop_valid_o=0. On input xfer: capture payload into word_q and
//   flag into last_q, set beat_idx=0, go to SHIFT.
// - FSM SHIFT: pop_valid_o=1, pop_data_o=word_q[beat_idx*SER_WIDTH +: SER_WIDTH].
//   pop_last_o=last_q & (beat_idx==BEATS-1).
// - SHIFT, output xfer and beat_idx<BEATS-1: increment beat_idx.
// - SHIFT, output xfer and beat_idx==BEATS-1 (final beat):
//   push_grant_o=1 in that same cycle (combinational from pop_grant_i).
//   If push_valid_i: load the next word, beat_idx=0, stay in SHIFT. This is back-to-back
//   operation with no bubble.
//   Else: go to IDLE.
// - SHIFT, all other cycles: push_grant_o=0.
// - Latency: the first beat of a word appears 1 cycle after its input xfer.
//   Throughput is 1 beat/cycle while pop_grant_i=1.
// - Backpressure: while pop_grant_i=0 in SHIFT, pop_data_o, pop_last_o and pop_valid_o hold
//   stable. Once raised, pop_valid_o never drops without an output xfer.
// - pkt_count_o increments by 1 on an output xfer with pop_last_o=1.
//   It wraps modulo 2**CNT_WIDTH and never saturates.
// - BEATS==1 (SER_WIDTH==DATA_WIDTH): every output xfer is a final beat; the pass-through
//   timing rules above still apply.
// - rst asserted mid-word: the partial word is discarded and all outputs return to reset
//   values immediately. The FIFO word already granted is lost, by design.
// - push_data_i is only sampled on an input xfer; X on it at other times must not propagate.
// STRUCTURE
// - Package fifo_ser_pkg:
//   typedef enum logic [0:0] {IDLE, SHIFT} ser_state_t;
//   function beats(dw, sw) returning dw/sw.
// - Single module, no sub-module. One always_ff for state, beat_idx, word_q, last_q and the
//   counter; one always_comb for the outputs.
// - beat_idx width is $clog2(BEATS), minimum 1.
// TESTING
// - Reset then idle: push_valid_i=0 -> pop_valid_o=0, push_grant_o=1, pkt_count_o=0.
// - Single word 33'h1_DDCCBBAA, pop_grant_i=1 -> beats AA,BB,CC,DD on 4 consecutive cycles;
//   pop_last_o=1 on DD only; pkt_count_o=1.
// - Back-to-back: words 0_04030201 and 1_08070605, push_valid_i held high ->
//   8 beats 01..08 with no gaps; push_grant_o pulses on cycles 0 and 4; pop_last_o on 08.
// - Backpressure: pop_grant_i=0 for 3 cycles on beat BB -> BB, pop_last_o and pop_valid_o
//   are held for the stall; no beat lost or duplicated.
// - Reset mid-word: assert rst after beat AA -> outputs return to reset values at once.
//   After release, the next word 1_44332211 emits 11,22,33,44 and pkt_count_o=1.
// - Counter wrap (CNT_WIDTH=2): 5 single-word packets -> pkt_count_o goes 1,2,3,0,1.

Source files
------------

// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO word serializer.
package fifo_ser_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Number of narrow beats carried by one wide payload word.
  function automatic int beats(input int dw, input int sw);
    return dw / sw;
  endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops wide words (payload plus end-of-packet flag) from a FIFO and emits
// them as narrow beats, least significant beat first, over a valid/grant
// stream. Final beats of consecutive words chain with no idle cycle, and a
// running count of completed packets is kept.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SER_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   push_data_i,
  input  logic                  push_valid_i,
  output logic                  push_grant_o,
  output logic [SER_WIDTH-1:0]  pop_data_o,
  output logic                  pop_last_o,
  output logic                  pop_valid_o,
  input  logic                  pop_grant_i,
  output logic [CNT_WIDTH-1:0]  pkt_count_o
);

  localparam int BEATS = beats(DATA_WIDTH, SER_WIDTH);
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  if ((DATA_WIDTH % SER_WIDTH) != 0) begin : g_width_check
    $error("fifo_word_serializer: DATA_WIDTH must be a multiple of SER_WIDTH");
  end

  ser_state_t             state;
  logic [IDX_W-1:0]       beat_idx;
  logic [DATA_WIDTH-1:0]  word_q;
  logic                   last_q;
  logic [CNT_WIDTH-1:0]   pkt_cnt;

  logic [DATA_WIDTH-1:0]  word_shifted;
  logic                   final_beat;
  logic                   in_xfer;
  logic                   out_xfer;

  // Beat selection by shifting keeps the index arithmetic free of part-select width issues.
  assign word_shifted = word_q >> (int'(beat_idx) * SER_WIDTH);
  assign final_beat   = (beat_idx == LAST_IDX);
  assign in_xfer      = push_valid_i & push_grant_o;
  assign out_xfer     = pop_valid_o & pop_grant_i;
  assign pkt_count_o  = pkt_cnt;

  // Output decode: the FIFO is granted while idle, or on the accepted final
  // beat so the next word loads without a bubble.
  always_comb begin
    pop_valid_o  = 1'b0;
    pop_data_o   = '0;
    pop_last_o   = 1'b0;
    push_grant_o = 1'b0;
    case (state)
      IDLE: begin
        push_grant_o = 1'b1;
      end
      SHIFT: begin
        pop_valid_o  = 1'b1;
        pop_data_o   = word_shifted[SER_WIDTH-1:0];
        pop_last_o   = last_q & final_beat;
        push_grant_o = pop_grant_i & final_beat;
      end
      default: begin
        push_grant_o = 1'b0;
      end
    endcase
  end

  // Sequencer: word capture, beat stepping and packet counting. Reset
  // discards any partially emitted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_idx <= '0;
      word_q   <= '0;
      last_q   <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      if (out_xfer && pop_last_o) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_xfer) begin
            word_q   <= push_data_i[DATA_WIDTH-1:0];
            last_q   <= push_data_i[DATA_WIDTH];
            beat_idx <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_xfer) begin
            if (!final_beat) begin
              beat_idx <= beat_idx + 1'b1;
            end else if (in_xfer) begin
              word_q   <= push_data_i[DATA_WIDTH-1:0];
              last_q   <= push_data_i[DATA_WIDTH];
              beat_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: a 4-beat instance with a 2-bit packet
// counter and a 1-beat pass-through instance share the same stimulus. Each
// is compared every cycle against a queue-of-pending-beats reference model.
module tb_fifo_word_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] push_data = '0;
  logic        push_valid = 1'b0;
  logic        pop_grant = 1'b0;

  logic        a_push_grant, a_pop_last, a_pop_valid;
  logic [7:0]  a_pop_data;
  logic [1:0]  a_pkt_count;
  logic        b_push_grant, b_pop_last, b_pop_valid;
  logic [31:0] b_pop_data;
  logic [15:0] b_pkt_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Pending beats of the word in flight: {last, data}.
  logic [8:0]  qa[$];
  logic [32:0] qb[$];
  int          ca = 0;
  int          cb = 0;
  bit          took_a;

  always #5 clk = ~clk;

  fifo_word_serializer #(.DATA_WIDTH(32), .SER_WIDTH(8), .CNT_WIDTH(2)) dut_a (
    .clk(clk), .rst(rst),
    .push_data_i(push_data), .push_valid_i(push_valid), .push_grant_o(a_push_grant),
    .pop_data_o(a_pop_data), .pop_last_o(a_pop_last), .pop_valid_o(a_pop_valid),
    .pop_grant_i(pop_grant), .pkt_count_o(a_pkt_count)
  );

  fifo_word_serializer #(.DATA_WIDTH(32), .SER_WIDTH(32), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst),
    .push_data_i(push_data), .push_valid_i(push_valid), .push_grant_o(b_push_grant),
    .pop_data_o(b_pop_data), .pop_last_o(b_pop_last), .pop_valid_o(b_pop_valid),
    .pop_grant_i(pop_grant), .pkt_count_o(b_pkt_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("a_rst_valid", a_pop_valid, 0);
    check("a_rst_data",  a_pop_data, 0);
    check("a_rst_last",  a_pop_last, 0);
    check("a_rst_grant", a_push_grant, 1);
    check("a_rst_count", a_pkt_count, 0);
    check("b_rst_valid", b_pop_valid, 0);
    check("b_rst_data",  b_pop_data, 0);
    check("b_rst_last",  b_pop_last, 0);
    check("b_rst_grant", b_push_grant, 1);
    check("b_rst_count", b_pkt_count, 0);
  endtask

  // One clock cycle: apply inputs, compare outputs with the model, advance the model.
  task automatic step(input logic pv, input logic [32:0] pd, input logic pg);
    bit va, ga, vb, gb;
    push_valid = pv;
    push_data  = pd;
    pop_grant  = pg;
    #1;
    va = (qa.size() != 0);
    ga = (qa.size() == 0) || (qa.size() == 1 && pg);
    vb = (qb.size() != 0);
    gb = (qb.size() == 0) || (qb.size() == 1 && pg);
    check("a_valid", a_pop_valid, va);
    check("a_grant", a_push_grant, ga);
    check("a_count", a_pkt_count, ca);
    if (va) begin
      check("a_data", a_pop_data, qa[0][7:0]);
      check("a_last", a_pop_last, qa[0][8]);
    end
    check("b_valid", b_pop_valid, vb);
    check("b_grant", b_push_grant, gb);
    check("b_count", b_pkt_count, cb);
    if (vb) begin
      check("b_data", b_pop_data, qb[0][31:0]);
      check("b_last", b_pop_last, qb[0][32]);
    end
    if (va && pg) begin
      if (qa[0][8]) ca = (ca + 1) % 4;
      void'(qa.pop_front());
    end
    if (vb && pg) begin
      if (qb[0][32]) cb = (cb + 1) % 65536;
      void'(qb.pop_front());
    end
    took_a = ga && pv;
    if (took_a) begin
      for (int b = 0; b < 4; b++) qa.push_back({pd[32] && (b == 3), pd[b*8 +: 8]});
    end
    if (gb && pv) qb.push_back(pd);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [32:0] w);
    int guard = 0;
    do begin
      step(1'b1, w, 1'b1);
      guard++;
    end while (!took_a && guard < 50);
    if (!took_a) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((qa.size() != 0 || qb.size() != 0) && guard < 50) begin
      step(1'b0, {1'b0, $urandom}, 1'b1);
      guard++;
    end
    step(1'b0, {1'b0, $urandom}, 1'b1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    push_valid = 1'b0;
    #1;
    check_reset_values();
    qa.delete();
    qb.delete();
    ca = 0;
    cb = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Power-up reset, then idle.
    #2;
    check_reset_values();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Single flagged word.
    send_word(33'h1_DDCCBBAA);
    drain();
    check("single_count", a_pkt_count, 1);

    // Back-to-back words with push_valid held high.
    step(1'b1, 33'h0_04030201, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 33'h1_08070605, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    drain();

    // Backpressure: stall three cycles while BB is presented.
    send_word(33'h1_DDCCBBAA);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    drain();

    // Reset after the first beat of a word.
    apply_reset();
    send_word(33'h1_DDCCBBAA);
    step(1'b0, '0, 1'b1);
    apply_reset();
    send_word(33'h1_44332211);
    drain();
    check("post_reset_count", a_pkt_count, 1);

    // Packet counter wrap on the 2-bit counter.
    apply_reset();
    for (int p = 0; p < 5; p++) begin
      send_word({1'b1, $urandom});
      drain();
    end
    check("wrap_count", a_pkt_count, 1);

    // Random traffic with random backpressure and unflagged words.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), $urandom},
           1'($urandom_range(0, 9) < 7));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
